// File: rtl/cs_pkg.sv
// Shared constants and elaboration-time helpers for the CS approximate-average filter.
package cs_pkg;

  localparam int CS_DATA_W    = 8;
  localparam int CS_WIN       = 9;
  localparam int CS_DIV_SHIFT = 3;
  localparam int CS_OUT_W     = 10;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // SUM_W = DATA_W + clog2(WIN) is wide enough for WIN full-scale samples.
  function automatic int sum_w(input int data_w, input int win);
    return data_w + clog2(win);
  endfunction

  localparam int CS_SUM_W   = sum_w(CS_DATA_W, CS_WIN);
  localparam int CS_T_W     = CS_SUM_W + 1;
  localparam int CS_OUT_MAX = (1 << CS_OUT_W) - 1;

endpackage

// File: rtl/cs_approx_select.sv
// Picks the largest window sample x with WIN*x <= S (no divider) via a max tree.
module cs_approx_select
  import cs_pkg::*;
#(
  parameter int DATA_W = CS_DATA_W,
  parameter int WIN    = CS_WIN,
  parameter int SUM_W  = CS_SUM_W
) (
  input  logic [WIN*DATA_W-1:0] win_i,
  input  logic [SUM_W-1:0]      sum_i,
  output logic [DATA_W-1:0]     xappr_o
);

  localparam int P = 1 << clog2(WIN);

  logic [WIN-1:0]    ok_s;
  logic [DATA_W-1:0] lvl_s [P];

  // Per-sample qualification against the window sum.
  always_comb begin
    for (int i = 0; i < WIN; i++) begin
      ok_s[i] = ((SUM_W'(WIN) * SUM_W'(win_i[i*DATA_W +: DATA_W])) <= sum_i);
    end
  end

  // Disqualified and padding leaves are 0, which never beats a qualifying sample.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      lvl_s[i] = {DATA_W{1'b0}};
    end
    for (int i = 0; i < WIN; i++) begin
      if (ok_s[i]) begin
        lvl_s[i] = win_i[i*DATA_W +: DATA_W];
      end else begin
        lvl_s[i] = {DATA_W{1'b0}};
      end
    end
    for (int s = P / 2; s >= 1; s = s / 2) begin
      for (int i = 0; i < s; i++) begin
        lvl_s[i] = (lvl_s[2*i] > lvl_s[2*i+1]) ? lvl_s[2*i] : lvl_s[2*i+1];
      end
    end
    xappr_o = lvl_s[0];
  end

endmodule

// File: rtl/cs_filter_param.sv
// Two-stage sliding-window filter: Y = sat((S + WIN*Xappr) >> DIV_SHIFT), valid only once the window is full.
module cs_filter_param
  import cs_pkg::*;
#(
  parameter int DATA_W    = CS_DATA_W,
  parameter int WIN       = CS_WIN,
  parameter int DIV_SHIFT = CS_DIV_SHIFT,
  parameter int OUT_W     = CS_OUT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] X,
  output logic              out_valid,
  output logic [OUT_W-1:0]  Y
);

  localparam int SUM_W  = sum_w(DATA_W, WIN);
  localparam int T_W    = SUM_W + 1;
  localparam int FILL_W = clog2(WIN + 1);
  localparam int CMP_W  = (T_W > OUT_W) ? T_W : OUT_W;

  logic [WIN*DATA_W-1:0] win_q, win_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  v1_q, v1_d;
  logic                  ov_q;
  logic [OUT_W-1:0]      y_q, y_d;
  logic [DATA_W-1:0]     xappr_s;
  logic [T_W-1:0]        t_s, r_s;

  // Stage 1 next state: window shift, running sum and fill tracking.
  always_comb begin
    win_d  = win_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    v1_d   = 1'b0;
    if (in_valid) begin
      win_d  = {win_q[(WIN-1)*DATA_W-1:0], X};
      sum_d  = sum_q + SUM_W'(X) - SUM_W'(win_q[WIN*DATA_W-1 -: DATA_W]);
      fill_d = (fill_q == FILL_W'(WIN)) ? fill_q : fill_q + FILL_W'(1);
      v1_d   = (fill_q >= FILL_W'(WIN - 1));
    end else begin
      v1_d   = 1'b0;
    end
  end

  cs_approx_select #(
    .DATA_W (DATA_W),
    .WIN    (WIN),
    .SUM_W  (SUM_W)
  ) u_sel (
    .win_i   (win_q),
    .sum_i   (sum_q),
    .xappr_o (xappr_s)
  );

  // Stage 2 result with saturation to the output range.
  always_comb begin
    t_s = T_W'(sum_q) + T_W'(SUM_W'(WIN) * SUM_W'(xappr_s));
    r_s = t_s >> DIV_SHIFT;
    if (CMP_W'(r_s) > CMP_W'({OUT_W{1'b1}})) begin
      y_d = {OUT_W{1'b1}};
    end else begin
      y_d = OUT_W'(r_s);
    end
  end

  // Pipeline registers; Y only updates alongside a valid result.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q  <= {(WIN*DATA_W){1'b0}};
      sum_q  <= {SUM_W{1'b0}};
      fill_q <= {FILL_W{1'b0}};
      v1_q   <= 1'b0;
      ov_q   <= 1'b0;
      y_q    <= {OUT_W{1'b0}};
    end else begin
      win_q  <= win_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
      v1_q   <= v1_d;
      ov_q   <= v1_q;
      if (v1_q) begin
        y_q <= y_d;
      end else begin
        y_q <= y_q;
      end
    end
  end

  assign out_valid = ov_q;
  assign Y         = y_q;

endmodule

// File: tb/tb_cs_filter_param.sv
// Scoreboard bench for cs_filter_param: default instance (OUT_W=10) plus an OUT_W=9 instance on the same stimulus.
module tb_cs_filter_param;

  localparam int WIN = 9;
  localparam int DIV_SHIFT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] X;
  logic       out_valid, out_valid9;
  logic [9:0] Y;
  logic [8:0] Y9;

  always #5 clk = ~clk;

  cs_filter_param dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .X(X),
    .out_valid(out_valid), .Y(Y)
  );

  cs_filter_param #(.OUT_W(9)) dut9 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .X(X),
    .out_valid(out_valid9), .Y(Y9)
  );

  typedef struct {
    int due;
    int y10;
    int y9;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int mwin[WIN];
  int mfill, msum;
  int hold_y, hold_y9;
  int n_res;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < WIN; i++) mwin[i] = 0;
    mfill = 0;
    msum = 0;
    hold_y = 0;
    hold_y9 = 0;
    sb.delete();
  endtask

  task automatic model_push(input int x);
    int best, t, r;
    exp_t e;
    msum = msum - mwin[WIN-1] + x;
    for (int i = WIN - 1; i > 0; i--) mwin[i] = mwin[i-1];
    mwin[0] = x;
    if (mfill < WIN) mfill++;
    if (mfill == WIN) begin
      best = -1;
      for (int i = 0; i < WIN; i++)
        if (WIN * mwin[i] <= msum && mwin[i] > best) best = mwin[i];
      t = msum + WIN * best;
      r = t >> DIV_SHIFT;
      e.due = cyc + 2;
      e.y10 = (r > 1023) ? 1023 : r;
      e.y9  = (r > 511) ? 511 : r;
      sb.push_back(e);
    end
  endtask

  // One cycle: check outputs at the falling edge, then drive the next inputs.
  task automatic tick(input bit rst, input bit v, input int x);
    exp_t e;
    @(negedge clk);
    cyc++;
    check_val("ov_pair", out_valid9, out_valid);
    if (out_valid) begin
      if (sb.size() == 0) begin
        check_val("spurious_ov", out_valid, 0);
      end else begin
        e = sb.pop_front();
        check_val("latency", cyc, e.due);
        check_val("y", Y, e.y10);
        check_val("y9", Y9, e.y9);
        hold_y = e.y10;
        hold_y9 = e.y9;
        n_res++;
      end
    end else begin
      check_val("y_hold", Y, hold_y);
      check_val("y9_hold", Y9, hold_y9);
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        check_val("missing_ov", out_valid, 1);
        void'(sb.pop_front());
      end
    end
    reset = rst;
    in_valid = v;
    X = x[7:0];
    if (rst) model_clear();
    else if (v) model_push(x);
  endtask

  task automatic restart();
    tick(1'b1, 1'b0, 0);
    n_res = 0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    X = 8'd0;
    model_clear();
    n_res = 0;
    repeat (3) @(negedge clk);
    check_val("rst_y", Y, 0);
    check_val("rst_ov", out_valid, 0);

    // 1..9 then 10
    restart();
    for (int i = 1; i <= 9; i++) tick(1'b0, 1'b1, i);
    tick(1'b0, 1'b1, 10);
    repeat (3) tick(1'b0, 1'b0, 0);
    check_val("p1_nres", n_res, 2);
    check_val("p1_y", Y, 13);

    // full-scale samples: 573 unsaturated, 511 at OUT_W=9
    restart();
    repeat (9) tick(1'b0, 1'b1, 255);
    repeat (3) tick(1'b0, 1'b0, 0);
    check_val("p2_y", Y, 573);
    check_val("p2_y9", Y9, 511);

    // gaps between accepted samples
    restart();
    for (int i = 1; i <= 9; i++) begin
      tick(1'b0, 1'b1, i);
      tick(1'b0, 1'b0, 0);
    end
    repeat (3) tick(1'b0, 1'b0, 0);
    check_val("p3_nres", n_res, 1);
    check_val("p3_y", Y, 11);

    // mid-stream reset, with a sample presented in the reset cycle
    restart();
    repeat (5) tick(1'b0, 1'b1, 200);
    tick(1'b1, 1'b1, 77);
    n_res = 0;
    for (int i = 1; i <= 9; i++) tick(1'b0, 1'b1, i);
    repeat (3) tick(1'b0, 1'b0, 0);
    check_val("p4_nres", n_res, 1);
    check_val("p4_y", Y, 11);

    // strict <= compare: only 0 qualifies
    restart();
    repeat (8) tick(1'b0, 1'b1, 9);
    tick(1'b0, 1'b1, 0);
    repeat (3) tick(1'b0, 1'b0, 0);
    check_val("p5_y", Y, 9);

    // random stream with sparse valids and occasional resets
    restart();
    for (int i = 0; i < 400; i++)
      tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 255));
    tick(1'b0, 1'b0, 0);
    repeat (3) tick(1'b0, 1'b0, 0);
    check_val("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
